cp0_exc_ctrl: RTL and testbench

Coprocessor-0 and precise exception/interrupt controller for the five-stage MIPS pipeline. Sits at the M stage: consumes the per-instruction ExcCode from the M-stage exception detector, external interrupt lines and `eret`/`mtc0`/`mfc0` from the M-stage instruction, and decides when the pipeline flushes and redirects. Holds SR, Cause, EPC and PRId, and tracks handler entry and exit through the SR.EXL state bit.

---
 rtl/cp0_pkg.sv | 51 +++++
 rtl/cp0_int_sync.sv | 28 ++
 rtl/cp0_exc_ctrl.sv | 127 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions
// and packing helpers for the SR and Cause views seen by mfc0.
package cp0_pkg;

    localparam int IRQ_W = 6;
    localparam int EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT       = 32'h4341_5000;

    function automatic logic [31:0] pack_sr(input logic [IRQ_W-1:0] im,
                                            input logic exl,
                                            input logic ie);
        logic [31:0] r;
        r = '0;
        r[SR_IM_LSB +: IRQ_W] = im;
        r[SR_EXL_BIT]         = exl;
        r[SR_IE_BIT]          = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic [IRQ_W-1:0] ip,
                                               input logic [EXC_W-1:0] code);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]               = bd;
        r[CAUSE_IP_LSB +: IRQ_W]      = ip;
        r[CAUSE_EXC_LSB +: EXC_W]     = code;
        return r;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt lines.
module cp0_int_sync
    import cp0_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IRQ_W-1:0] async_i,
    output logic [IRQ_W-1:0] sync_o
);

    logic [IRQ_W-1:0] meta_q;
    logic [IRQ_W-1:0] sync_q;

    // NOTE: non-blocking assignments make both flops sample the old values,
    // so the chain really is two stages deep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and precise exception/interrupt controller at the M stage.
// Handler mode is tracked by SR.EXL; flush/redirect are decided combinationally.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic             m_bd,
    input  logic [EXC_W-1:0] m_exc_code,
    input  logic             m_eret,
    input  logic             m_mtc0_we,
    input  logic [4:0]       m_cp0_addr,
    input  logic [31:0]      m_cp0_wdata,
    input  logic [IRQ_W-1:0] hw_int,
    output logic [31:0]      cp0_rdata,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      epc
);

    logic [IRQ_W-1:0] ip_sync;

    logic [IRQ_W-1:0] sr_im_q, sr_im_d;
    logic             sr_exl_q, sr_exl_d;
    logic             sr_ie_q, sr_ie_d;
    logic             cause_bd_q, cause_bd_d;
    logic [EXC_W-1:0] cause_exc_q, cause_exc_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      last_pc_q, last_pc_d;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        eret_go;
    logic [31:0] victim_pc;

    // The synchroniser output is the Cause.IP field itself.
    cp0_int_sync u_int_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (hw_int),
        .sync_o  (ip_sync)
    );

    // Gating with reset_n keeps flush low while held in reset even if the
    // detector presents a stale ExcCode.
    assign int_req   = sr_ie_q & ~sr_exl_q & (|(sr_im_q & ip_sync));
    assign exc_req   = ~sr_exl_q & m_valid & (m_exc_code != EXC_INT);
    assign take      = reset_n & (int_req | exc_req);
    assign eret_go   = reset_n & m_eret & ~take;
    assign victim_pc = m_valid ? m_pc : last_pc_q;

    assign flush       = take | eret_go;
    assign redirect_pc = take ? HANDLER_PC : epc_q;
    assign epc         = epc_q;

    always_comb begin
        cp0_rdata = '0;
        case (m_cp0_addr)
            CP0_SR:    cp0_rdata = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
            CP0_CAUSE: cp0_rdata = pack_cause(cause_bd_q, ip_sync, cause_exc_q);
            CP0_EPC:   cp0_rdata = epc_q;
            CP0_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = '0;
        endcase
    end

    // NOTE: every next-state signal is defaulted to its current value first,
    // so no path through the branches below can infer a latch.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        last_pc_d   = m_valid ? m_pc + 32'd4 : last_pc_q;

        if (take) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : m_exc_code;
            cause_bd_d  = m_bd;
            epc_d       = m_bd ? victim_pc - 32'd4 : victim_pc;
        end else begin
            if (m_mtc0_we) begin
                case (m_cp0_addr)
                    CP0_SR: begin
                        sr_im_d  = m_cp0_wdata[SR_IM_LSB +: IRQ_W];
                        sr_exl_d = m_cp0_wdata[SR_EXL_BIT];
                        sr_ie_d  = m_cp0_wdata[SR_IE_BIT];
                    end
                    CP0_EPC: epc_d = {m_cp0_wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (eret_go) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= '0;
            epc_q       <= '0;
            last_pc_q   <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
            last_pc_q   <= last_pc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios followed by random
// M-stage traffic, all compared against a word-level CP0 model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID_VAL = 32'h4341_5000;
    localparam logic [31:0] HPC      = 32'h0000_4180;
    localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic        m_mtc0_we;
    logic [4:0]  m_cp0_addr;
    logic [31:0] m_cp0_wdata;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] epc;

    cp0_exc_ctrl #(.PRID(PRID_VAL), .HANDLER_PC(HPC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_bd        (m_bd),
        .m_exc_code  (m_exc_code),
        .m_eret      (m_eret),
        .m_mtc0_we   (m_mtc0_we),
        .m_cp0_addr  (m_cp0_addr),
        .m_cp0_wdata (m_cp0_wdata),
        .hw_int      (hw_int),
        .cp0_rdata   (cp0_rdata),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: SR kept as its architectural word, Cause as BD + code,
    // interrupt lines as a two-entry sample history.
    logic [31:0] mdl_sr, mdl_epc, mdl_last_pc;
    logic        mdl_bd;
    logic [4:0]  mdl_code;
    logic [5:0]  mdl_s1, mdl_s2;

    task automatic mdl_reset();
        mdl_sr = 0; mdl_epc = 0; mdl_last_pc = 0;
        mdl_bd = 0; mdl_code = 0; mdl_s1 = 0; mdl_s2 = 0;
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        case (a)
            5'd12:   return mdl_sr;
            5'd13:   return {mdl_bd, 15'b0, mdl_s2, 3'b0, mdl_code, 2'b00};
            5'd14:   return mdl_epc;
            5'd15:   return PRID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    // Called at a negedge with inputs already driven; checks the cycle, then
    // advances the model across the next rising edge.
    task automatic tick(input string tag);
        logic        int_req, exc_req, take, eret_go;
        logic [31:0] victim;
        if (!reset_n) mdl_reset();
        int_req = reset_n && mdl_sr[0] && !mdl_sr[1] && ((mdl_sr[15:10] & mdl_s2) != 0);
        exc_req = reset_n && !mdl_sr[1] && m_valid && (m_exc_code != 0);
        take    = int_req || exc_req;
        eret_go = reset_n && m_eret && !take;
        #1;
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, take || eret_go});
        if (take) check({tag, ".redir_h"}, redirect_pc, HPC);
        else if (eret_go) check({tag, ".redir_e"}, redirect_pc, mdl_epc);
        check({tag, ".epc"}, epc, mdl_epc);
        check({tag, ".rdata"}, cp0_rdata, mdl_read(m_cp0_addr));
        if (!reset_n) begin
            @(negedge clk);
            return;
        end
        @(posedge clk);
        victim = m_valid ? m_pc : mdl_last_pc;
        if (take) begin
            mdl_sr[1] = 1'b1;
            mdl_code  = int_req ? 5'd0 : m_exc_code;
            mdl_bd    = m_bd;
            mdl_epc   = m_bd ? victim - 4 : victim;
        end else begin
            if (m_mtc0_we && m_cp0_addr == 5'd12) mdl_sr  = m_cp0_wdata & SR_MASK;
            if (m_mtc0_we && m_cp0_addr == 5'd14) mdl_epc = m_cp0_wdata & ~32'h3;
            if (eret_go) mdl_sr[1] = 1'b0;
        end
        if (m_valid) mdl_last_pc = m_pc + 4;
        mdl_s2 = mdl_s1;
        mdl_s1 = hw_int;
        @(negedge clk);
    endtask

    task automatic idle();
        m_valid = 0; m_pc = 0; m_bd = 0; m_exc_code = 0;
        m_eret = 0; m_mtc0_we = 0; m_cp0_wdata = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic bd, input logic [4:0] code);
        idle();
        m_valid = 1; m_pc = pc; m_bd = bd; m_exc_code = code;
    endtask

    logic [31:0] rd_exp [4];

    initial begin
        reset_n = 0; hw_int = 0; m_cp0_addr = 0;
        idle();
        mdl_reset();
        rd_exp[0] = 32'h0; rd_exp[1] = 32'h0; rd_exp[2] = 32'h0; rd_exp[3] = PRID_VAL;
        @(negedge clk);
        tick("rst");
        reset_n = 1;

        // Reset values through mfc0.
        for (int i = 0; i < 4; i++) begin
            m_cp0_addr = 5'(12 + i);
            #1 check("rst_rd", cp0_rdata, rd_exp[i]);
            tick("rst_rd");
        end

        // Overflow exception, not in a delay slot.
        instr(32'h3004, 0, 5'd12); m_cp0_addr = 5'd13;
        #1 check("ov_flush", {31'b0, flush}, 32'd1);
        check("ov_redir", redirect_pc, HPC);
        tick("ov");
        idle();
        #1 check("ov_epc", epc, 32'h3004);
        check("ov_cause", cp0_rdata, 32'h0000_0030);
        tick("ov_c");
        m_cp0_addr = 5'd12;
        #1 check("ov_sr", cp0_rdata, 32'h0000_0002);
        tick("ov_s");
        instr(32'h4180, 0, 0); m_eret = 1;
        tick("ov_eret");

        // AdEL in a delay slot.
        instr(32'h3004, 1, 5'd4); m_cp0_addr = 5'd13;
        tick("bd");
        idle();
        #1 check("bd_epc", epc, 32'h3000);
        check("bd_cause", cp0_rdata, 32'h8000_0010);
        tick("bd_c");
        instr(32'h4184, 0, 0); m_eret = 1;
        tick("bd_eret");

        // Interrupt taken on a bubble after the synchroniser delay.
        instr(32'h3008, 0, 0); m_mtc0_we = 1; m_cp0_addr = 5'd12; m_cp0_wdata = 32'h0000_0401;
        tick("sr_wr");
        instr(32'h3010, 0, 0);
        tick("pc3010");
        idle(); hw_int = 6'b000001;
        #1 check("irq_c0", {31'b0, flush}, 32'd0);
        tick("irq0");
        #1 check("irq_c1", {31'b0, flush}, 32'd0);
        tick("irq1");
        #1 check("irq_c2", {31'b0, flush}, 32'd1);
        check("irq_redir", redirect_pc, HPC);
        tick("irq2");
        m_cp0_addr = 5'd13;
        #1 check("irq_epc", epc, 32'h3014);
        check("irq_cause", cp0_rdata, 32'h0000_0400);

        // Exceptions are masked in the handler; eret returns.
        instr(32'h4180, 0, 5'd5); hw_int = 0;
        #1 check("hnd_mask", {31'b0, flush}, 32'd0);
        tick("hnd_ades");
        idle();
        tick("hnd_bub");
        instr(32'h4184, 0, 0); m_eret = 1; m_cp0_addr = 5'd12;
        #1 check("eret_flush", {31'b0, flush}, 32'd1);
        check("eret_redir", redirect_pc, 32'h3014);
        tick("eret");
        idle();
        #1 check("eret_sr", cp0_rdata, 32'h0000_0401);
        tick("eret_s");

        // Take suppresses a same-cycle mtc0; reset mid-handler.
        instr(32'h3100, 0, 5'd12); m_mtc0_we = 1; m_cp0_addr = 5'd12; m_cp0_wdata = 0;
        tick("sup");
        idle();
        #1 check("sup_sr", cp0_rdata, 32'h0000_0403);
        tick("sup_s");
        instr(32'h3200, 0, 5'd12); reset_n = 0;
        #1 check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_sr", cp0_rdata, 32'h0);
        tick("rst_mid");
        idle();
        reset_n = 1;
        tick("rst_rel");

        // Random M-stage traffic.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] kind;
            idle();
            m_valid = ($urandom_range(0, 3) != 0);
            kind    = 4'($urandom_range(0, 11));
            if (m_valid) begin
                m_pc = $urandom() & 32'hFFFF_FFFC;
                m_bd = $urandom_range(0, 3) == 0;
                case ($urandom_range(0, 7))
                    0: m_exc_code = 5'd4;
                    1: m_exc_code = 5'd12;
                    2: m_exc_code = 5'd10;
                    default: m_exc_code = 5'd0;
                endcase
                if (kind == 0) m_eret = 1;
                else if (kind < 4) begin
                    m_mtc0_we   = 1;
                    m_cp0_wdata = $urandom();
                end
            end else begin
                m_exc_code = 5'($urandom_range(0, 31));
            end
            m_cp0_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'($urandom_range(12, 15));
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
